// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake and decoded control word of decode_stage.
// master: fetch/consumer side (drives start, instr_valid, instr).
// slave : decoder side (drives instr_ready, the control word, instr_count, halted).
// Encodings: registers 0..15 = r0..r15, 16 = no_reg; math 0..15, 16 = no_mth;
// reg_op 0 = no_rop (full list in decode_stage).
interface decode_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             instr_valid;
  logic [8:0]       instr;
  logic             instr_ready;
  logic             ctl_valid;
  logic [4:0]       reg_src;
  logic [4:0]       reg_dst;
  logic [4:0]       reg_op;
  logic [4:0]       math_op;
  logic             alu_en;
  logic             alu_rs;
  logic             mem_sel;
  logic             loadEn;
  logic             storEn;
  logic             done;
  logic             illegal;
  logic [3:0]       instr_o;
  logic [CNT_W-1:0] instr_count;
  logic             halted;

  modport master (
    output start, instr_valid, instr,
    input  instr_ready, ctl_valid, reg_src, reg_dst, reg_op, math_op, alu_en,
           alu_rs, mem_sel, loadEn, storEn, done, illegal, instr_o,
           instr_count, halted
  );

  modport slave (
    input  start, instr_valid, instr,
    output instr_ready, ctl_valid, reg_src, reg_dst, reg_op, math_op, alu_en,
           alu_rs, mem_sel, loadEn, storEn, done, illegal, instr_o,
           instr_count, halted
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked instruction decoder with load/store
// stall, run/halt FSM, optional trap on unused encodings and a saturating
// retired-instruction counter.
// Ports: clk (rising edge), reset (synchronous, active-high),
//        bus (decode_stage_if.slave): start/instr_valid/instr in,
//        instr_ready, one-cycle control word, instr_count, halted out.
module decode_stage #(
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter bit          TRAP_UNUSED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  localparam int unsigned STALL_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit          HAS_STALL = (MEM_LAT > 1);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(MEM_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [4:0] REG_NONE = 5'd16;
  localparam logic [4:0] MTH_NONE = 5'd16;

  localparam logic [4:0] ROP_NONE   = 5'd0;
  localparam logic [4:0] ROP_VAL_LO = 5'd1;
  localparam logic [4:0] ROP_VAL_HI = 5'd2;
  localparam logic [4:0] ROP_MOV    = 5'd3;
  localparam logic [4:0] ROP_INCR   = 5'd4;
  localparam logic [4:0] ROP_DECR   = 5'd5;
  localparam logic [4:0] ROP_JIZR   = 5'd6;
  localparam logic [4:0] ROP_JNZR   = 5'd7;
  localparam logic [4:0] ROP_BIZR   = 5'd8;
  localparam logic [4:0] ROP_BNZR   = 5'd9;
  localparam logic [4:0] ROP_J2SR   = 5'd10;
  localparam logic [4:0] ROP_LSLC   = 5'd11;
  localparam logic [4:0] ROP_LSRC   = 5'd12;
  localparam logic [4:0] ROP_FLIP   = 5'd13;
  localparam logic [4:0] ROP_LJP0   = 5'd14;
  localparam logic [4:0] ROP_LJP1   = 5'd15;
  localparam logic [4:0] ROP_LJP2   = 5'd16;
  localparam logic [4:0] ROP_LJP3   = 5'd17;
  localparam logic [4:0] ROP_FUNC   = 5'd18;
  localparam logic [4:0] ROP_RFSR   = 5'd19;

  typedef struct packed {
    logic       ctl_valid;
    logic [4:0] reg_src;
    logic [4:0] reg_dst;
    logic [4:0] reg_op;
    logic [4:0] math_op;
    logic       alu_en;
    logic       alu_rs;
    logic       mem_sel;
    logic       load_en;
    logic       stor_en;
    logic       done;
    logic       illegal;
    logic [3:0] instr_o;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{ctl_valid: 1'b0, reg_src: REG_NONE,
                                reg_dst: REG_NONE, reg_op: ROP_NONE,
                                math_op: MTH_NONE, alu_en: 1'b0, alu_rs: 1'b0,
                                mem_sel: 1'b0, load_en: 1'b0, stor_en: 1'b0,
                                done: 1'b0, illegal: 1'b0, instr_o: 4'd0};

  logic [1:0]         state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ctl_t               ctl_q, ctl_d;
  logic               ready_q, ready_d;
  logic               halted_q, halted_d;

  ctl_t               dec;
  logic               unused_enc;
  logic               accept;
  logic [3:0]         opc;
  logic               b4;

  assign opc    = bus.instr[8:5];
  assign b4     = bus.instr[4];
  assign accept = ready_q & bus.instr_valid;

  // Combinational decode of the presented instruction word.
  always_comb begin
    dec           = CTL_IDLE;
    dec.ctl_valid = 1'b1;
    dec.instr_o   = bus.instr[3:0];
    unused_enc    = 1'b0;
    if (opc == 4'd0) begin
      dec.reg_op = b4 ? ROP_VAL_HI : ROP_VAL_LO;
    end else if (!bus.instr[8]) begin
      dec.reg_op  = ROP_MOV;
      dec.reg_dst = 5'(bus.instr[7:4]);
      dec.reg_src = 5'(bus.instr[3:0]);
    end else begin
      case (opc)
        4'b1000: begin
          dec.mem_sel = bus.instr[3];
          if (!b4) begin
            dec.load_en = 1'b1;
            dec.reg_dst = 5'(bus.instr[2:0]);
          end else begin
            dec.stor_en = 1'b1;
            dec.reg_src = 5'(bus.instr[2:0]);
          end
        end
        4'b1001: begin
          dec.reg_op  = b4 ? ROP_DECR : ROP_INCR;
          dec.reg_src = 5'(bus.instr[3:0]);
          dec.reg_dst = 5'(bus.instr[3:0]);
        end
        4'b1010: dec.reg_op = b4 ? ROP_JNZR : ROP_JIZR;
        4'b1011: begin
          dec.reg_op  = b4 ? ROP_BNZR : ROP_BIZR;
          dec.reg_src = 5'(bus.instr[3:0]);
        end
        4'b1100: begin
          if (b4) unused_enc = 1'b1;
          else    dec.reg_op = ROP_J2SR;
        end
        4'b1101: begin
          dec.alu_en  = 1'b1;
          dec.alu_rs  = b4;
          dec.math_op = 5'(bus.instr[3:0]);
        end
        4'b1110: dec.reg_op = b4 ? ROP_LSRC : ROP_LSLC;
        4'b1111: begin
          if (!b4) begin
            dec.reg_op  = ROP_FLIP;
            dec.reg_src = 5'(bus.instr[3:0]);
          end else begin
            case (bus.instr[3:0])
              4'd0:         dec.reg_op = ROP_LJP0;
              4'd1:         dec.reg_op = ROP_LJP1;
              4'd2:         dec.reg_op = ROP_LJP2;
              4'd3:         dec.reg_op = ROP_LJP3;
              4'd4:         unused_enc = 1'b1;
              4'd12, 4'd13: dec.reg_op = ROP_FUNC;
              4'd14:        dec.reg_op = ROP_RFSR;
              default:      dec.done   = 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
    // Unused words: a defaults-only word, flagged illegal when trapping.
    if (unused_enc) begin
      dec           = CTL_IDLE;
      dec.ctl_valid = 1'b1;
      dec.illegal   = TRAP_UNUSED;
    end
  end

  // Next state, stall counter, registered control word and retire counter.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    cnt_d   = cnt_q;
    ctl_d   = CTL_IDLE;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          ctl_d = dec;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (dec.done || dec.illegal) begin
            state_d = S_HALT;
          end else if ((dec.load_en || dec.stor_en) && HAS_STALL) begin
            state_d = S_STALL;
            stall_d = STALL_LOAD;
          end
        end
      end
      S_STALL: begin
        stall_d = stall_q - STALL_W'(1);
        if (stall_q <= STALL_W'(1)) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake/status flops follow the upcoming state so they stay registered.
    ready_d  = (state_d == S_RUN);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stall_q  <= '0;
      cnt_q    <= '0;
      ctl_q    <= CTL_IDLE;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      cnt_q    <= cnt_d;
      ctl_q    <= ctl_d;
      ready_q  <= ready_d;
      halted_q <= halted_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.ctl_valid   = ctl_q.ctl_valid;
  assign bus.reg_src     = ctl_q.reg_src;
  assign bus.reg_dst     = ctl_q.reg_dst;
  assign bus.reg_op      = ctl_q.reg_op;
  assign bus.math_op     = ctl_q.math_op;
  assign bus.alu_en      = ctl_q.alu_en;
  assign bus.alu_rs      = ctl_q.alu_rs;
  assign bus.mem_sel     = ctl_q.mem_sel;
  assign bus.loadEn      = ctl_q.load_en;
  assign bus.storEn      = ctl_q.stor_en;
  assign bus.done        = ctl_q.done;
  assign bus.illegal     = ctl_q.illegal;
  assign bus.instr_o     = ctl_q.instr_o;
  assign bus.instr_count = cnt_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: two decode_stage instances.
//   dut_a: MEM_LAT=3, CNT_W=4, TRAP_UNUSED=0 -- hand sequences, then random
//          traffic against a cycle-level reference model.
//   dut_b: MEM_LAT=1, CNT_W=16, TRAP_UNUSED=1 -- table of decode vectors.
module tb_decode_stage;

  localparam int unsigned LAT_A = 3;

  localparam logic [4:0] R_NONE  = 5'd16;
  localparam logic [4:0] M_NONE  = 5'd16;
  localparam logic [4:0] OP_NONE = 5'd0;
  localparam logic [4:0] OP_VLO  = 5'd1;
  localparam logic [4:0] OP_VHI  = 5'd2;
  localparam logic [4:0] OP_MOV  = 5'd3;
  localparam logic [4:0] OP_INCR = 5'd4;
  localparam logic [4:0] OP_DECR = 5'd5;
  localparam logic [4:0] OP_JIZR = 5'd6;
  localparam logic [4:0] OP_JNZR = 5'd7;
  localparam logic [4:0] OP_BIZR = 5'd8;
  localparam logic [4:0] OP_BNZR = 5'd9;
  localparam logic [4:0] OP_J2SR = 5'd10;
  localparam logic [4:0] OP_LSLC = 5'd11;
  localparam logic [4:0] OP_LSRC = 5'd12;
  localparam logic [4:0] OP_FLIP = 5'd13;
  localparam logic [4:0] OP_LJP0 = 5'd14;
  localparam logic [4:0] OP_FUNC = 5'd18;
  localparam logic [4:0] OP_RFSR = 5'd19;

  // flag order: alu_en, alu_rs, mem_sel, loadEn, storEn, done, illegal
  localparam logic [6:0] F_NO  = 7'b0000000;
  localparam logic [6:0] F_ALU = 7'b1000000;
  localparam logic [6:0] F_RS  = 7'b0100000;
  localparam logic [6:0] F_MS  = 7'b0010000;
  localparam logic [6:0] F_LD  = 7'b0001000;
  localparam logic [6:0] F_ST  = 7'b0000100;
  localparam logic [6:0] F_DN  = 7'b0000010;
  localparam logic [6:0] F_IL  = 7'b0000001;

  typedef struct packed {
    logic       ctl_valid;
    logic [4:0] reg_src;
    logic [4:0] reg_dst;
    logic [4:0] reg_op;
    logic [4:0] math_op;
    logic       alu_en;
    logic       alu_rs;
    logic       mem_sel;
    logic       load_en;
    logic       stor_en;
    logic       done;
    logic       illegal;
    logic [3:0] instr_o;
  } ctl_t;

  typedef struct {
    logic [8:0] instr;
    ctl_t       exp;
  } vec_t;

  localparam ctl_t DEF = '{ctl_valid: 1'b0, reg_src: R_NONE, reg_dst: R_NONE,
                           reg_op: OP_NONE, math_op: M_NONE, alu_en: 1'b0,
                           alu_rs: 1'b0, mem_sel: 1'b0, load_en: 1'b0,
                           stor_en: 1'b0, done: 1'b0, illegal: 1'b0,
                           instr_o: 4'd0};

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.CNT_W(4))  bus_a ();
  decode_stage_if #(.CNT_W(16)) bus_b ();

  decode_stage #(.MEM_LAT(LAT_A), .CNT_W(4), .TRAP_UNUSED(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );

  decode_stage #(.MEM_LAT(1), .CNT_W(16), .TRAP_UNUSED(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ctl_t mk(input logic [4:0] op, input logic [4:0] src,
                              input logic [4:0] dst, input logic [4:0] mth,
                              input logic [3:0] io, input logic [6:0] fl);
    ctl_t c;
    c = DEF;
    c.ctl_valid = 1'b1;
    c.reg_op    = op;
    c.reg_src   = src;
    c.reg_dst   = dst;
    c.math_op   = mth;
    c.instr_o   = io;
    {c.alu_en, c.alu_rs, c.mem_sel, c.load_en, c.stor_en, c.done, c.illegal} = fl;
    return c;
  endfunction

  function automatic ctl_t get_a();
    ctl_t c;
    c = '{ctl_valid: bus_a.ctl_valid, reg_src: bus_a.reg_src, reg_dst: bus_a.reg_dst,
          reg_op: bus_a.reg_op, math_op: bus_a.math_op, alu_en: bus_a.alu_en,
          alu_rs: bus_a.alu_rs, mem_sel: bus_a.mem_sel, load_en: bus_a.loadEn,
          stor_en: bus_a.storEn, done: bus_a.done, illegal: bus_a.illegal,
          instr_o: bus_a.instr_o};
    return c;
  endfunction

  function automatic ctl_t get_b();
    ctl_t c;
    c = '{ctl_valid: bus_b.ctl_valid, reg_src: bus_b.reg_src, reg_dst: bus_b.reg_dst,
          reg_op: bus_b.reg_op, math_op: bus_b.math_op, alu_en: bus_b.alu_en,
          alu_rs: bus_b.alu_rs, mem_sel: bus_b.mem_sel, load_en: bus_b.loadEn,
          stor_en: bus_b.storEn, done: bus_b.done, illegal: bus_b.illegal,
          instr_o: bus_b.instr_o};
    return c;
  endfunction

  // Reference decode from the opcode rules, using plain arithmetic on the word.
  function automatic ctl_t model_decode(input logic [8:0] w, input bit trap);
    int unsigned v  = 32'(w);
    int unsigned d  = v >> 5;
    int unsigned b4 = (v >> 4) & 1;
    int unsigned lo = v & 15;
    bit   unused = 1'b0;
    ctl_t c = DEF;
    c.ctl_valid = 1'b1;
    c.instr_o   = 4'(lo);
    if (v < 32) begin
      c.reg_op = (b4 != 0) ? OP_VHI : OP_VLO;
    end else if (v < 256) begin
      c.reg_op  = OP_MOV;
      c.reg_dst = 5'((v >> 4) & 15);
      c.reg_src = 5'(lo);
    end else begin
      case (d)
        8: begin
          c.mem_sel = (lo >= 8);
          if (b4 == 0) begin c.load_en = 1'b1; c.reg_dst = 5'(lo % 8); end
          else         begin c.stor_en = 1'b1; c.reg_src = 5'(lo % 8); end
        end
        9:  begin c.reg_op = (b4 != 0) ? OP_DECR : OP_INCR; c.reg_src = 5'(lo); c.reg_dst = 5'(lo); end
        10: c.reg_op = (b4 != 0) ? OP_JNZR : OP_JIZR;
        11: begin c.reg_op = (b4 != 0) ? OP_BNZR : OP_BIZR; c.reg_src = 5'(lo); end
        12: if (b4 != 0) unused = 1'b1; else c.reg_op = OP_J2SR;
        13: begin c.alu_en = 1'b1; c.alu_rs = (b4 != 0); c.math_op = 5'(lo); end
        14: c.reg_op = (b4 != 0) ? OP_LSRC : OP_LSLC;
        default: begin
          if (b4 == 0)                begin c.reg_op = OP_FLIP; c.reg_src = 5'(lo); end
          else if (lo < 4)            c.reg_op = 5'(32'(OP_LJP0) + lo);
          else if (lo == 4)           unused = 1'b1;
          else if (lo == 12 || lo == 13) c.reg_op = OP_FUNC;
          else if (lo == 14)          c.reg_op = OP_RFSR;
          else                        c.done = 1'b1;
        end
      endcase
    end
    if (unused) begin
      c = DEF;
      c.ctl_valid = 1'b1;
      c.illegal   = trap;
    end
    return c;
  endfunction

  vec_t tbl[$];

  initial begin
    ctl_t       exp_ctl;
    ctl_t       c;
    logic [8:0] w;
    logic       valid;
    logic       start;
    logic       pend;
    logic       acc;
    bit         m_run;
    bit         m_halt;
    int         m_wait;
    int         m_cnt;
    int         b_cnt;
    int         lows;
    int         n;

    tbl.push_back('{9'h00A, mk(OP_VLO,  R_NONE, R_NONE, M_NONE, 4'hA, F_NO)});
    tbl.push_back('{9'h01F, mk(OP_VHI,  R_NONE, R_NONE, M_NONE, 4'hF, F_NO)});
    tbl.push_back('{9'h0A3, mk(OP_MOV,  5'd3,   5'd10,  M_NONE, 4'h3, F_NO)});
    tbl.push_back('{9'h10B, mk(OP_NONE, R_NONE, 5'd3,   M_NONE, 4'hB, F_LD | F_MS)});
    tbl.push_back('{9'h11C, mk(OP_NONE, 5'd4,   R_NONE, M_NONE, 4'hC, F_ST | F_MS)});
    tbl.push_back('{9'h103, mk(OP_NONE, R_NONE, 5'd3,   M_NONE, 4'h3, F_LD)});
    tbl.push_back('{9'h125, mk(OP_INCR, 5'd5,   5'd5,   M_NONE, 4'h5, F_NO)});
    tbl.push_back('{9'h137, mk(OP_DECR, 5'd7,   5'd7,   M_NONE, 4'h7, F_NO)});
    tbl.push_back('{9'h141, mk(OP_JIZR, R_NONE, R_NONE, M_NONE, 4'h1, F_NO)});
    tbl.push_back('{9'h15E, mk(OP_JNZR, R_NONE, R_NONE, M_NONE, 4'hE, F_NO)});
    tbl.push_back('{9'h169, mk(OP_BIZR, 5'd9,   R_NONE, M_NONE, 4'h9, F_NO)});
    tbl.push_back('{9'h176, mk(OP_BNZR, 5'd6,   R_NONE, M_NONE, 4'h6, F_NO)});
    tbl.push_back('{9'h182, mk(OP_J2SR, R_NONE, R_NONE, M_NONE, 4'h2, F_NO)});
    tbl.push_back('{9'h190, mk(OP_NONE, R_NONE, R_NONE, M_NONE, 4'h0, F_IL)});
    tbl.push_back('{9'h1B7, mk(OP_NONE, R_NONE, R_NONE, 5'd7,   4'h7, F_ALU | F_RS)});
    tbl.push_back('{9'h1C0, mk(OP_LSLC, R_NONE, R_NONE, M_NONE, 4'h0, F_NO)});
    tbl.push_back('{9'h1D3, mk(OP_LSRC, R_NONE, R_NONE, M_NONE, 4'h3, F_NO)});
    tbl.push_back('{9'h1E8, mk(OP_FLIP, 5'd8,   R_NONE, M_NONE, 4'h8, F_NO)});
    tbl.push_back('{9'h1F2, mk(5'd16,   R_NONE, R_NONE, M_NONE, 4'h2, F_NO)});
    tbl.push_back('{9'h1F4, mk(OP_NONE, R_NONE, R_NONE, M_NONE, 4'h0, F_IL)});
    tbl.push_back('{9'h1F9, mk(OP_NONE, R_NONE, R_NONE, M_NONE, 4'h9, F_DN)});
    tbl.push_back('{9'h1FC, mk(OP_FUNC, R_NONE, R_NONE, M_NONE, 4'hC, F_NO)});
    tbl.push_back('{9'h1FE, mk(OP_RFSR, R_NONE, R_NONE, M_NONE, 4'hE, F_NO)});
    tbl.push_back('{9'h1FF, mk(OP_NONE, R_NONE, R_NONE, M_NONE, 4'hF, F_DN)});

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.start = 1'b0; bus_a.instr_valid = 1'b0; bus_a.instr = '0;
    bus_b.start = 1'b0; bus_b.instr_valid = 1'b0; bus_b.instr = '0;
    cyc(); cyc();

    // ---------------- dut_a hand sequences ----------------
    chk("a_reset_ctl",    32'(get_a()), 32'(DEF));
    chk("a_reset_ready",  32'(bus_a.instr_ready), 32'd0);
    chk("a_reset_count",  32'(bus_a.instr_count), 32'd0);
    chk("a_reset_halted", 32'(bus_a.halted), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc();
    chk("a_idle_ready", 32'(bus_a.instr_ready), 32'd0);

    bus_a.start = 1'b1;
    cyc();
    bus_a.start = 1'b0;
    chk("a_start_ready", 32'(bus_a.instr_ready), 32'd1);
    bus_a.instr_valid = 1'b1; bus_a.instr = 9'h0A3;
    cyc();
    chk("a_mov_ctl",   32'(get_a()), 32'(mk(OP_MOV, 5'd3, 5'd10, M_NONE, 4'h3, F_NO)));
    chk("a_mov_count", 32'(bus_a.instr_count), 32'd1);
    for (int i = 0; i < 19; i++) cyc();
    chk("a_count_sat",  32'(bus_a.instr_count), 32'd15);
    chk("a_b2b_ready",  32'(bus_a.instr_ready), 32'd1);
    chk("a_b2b_valid",  32'(bus_a.ctl_valid), 32'd1);
    bus_a.instr_valid = 1'b0;
    cyc();
    chk("a_pulse_end", 32'(get_a()), 32'(DEF));

    // load with MEM_LAT=3, then add held valid through the stall
    bus_a.instr_valid = 1'b1; bus_a.instr = 9'h10B;
    cyc();
    chk("a_load_ctl",   32'(get_a()), 32'(mk(OP_NONE, R_NONE, 5'd3, M_NONE, 4'hB, F_LD | F_MS)));
    chk("a_load_ready", 32'(bus_a.instr_ready), 32'd0);
    bus_a.instr = 9'h1A2;
    lows = 1;
    n = 0;
    while (!bus_a.instr_ready && n < 10) begin
      cyc();
      n++;
      if (!bus_a.instr_ready) lows++;
    end
    chk("a_stall_cycles", 32'(lows), 32'(LAT_A - 1));
    chk("a_stall_nodec",  32'(bus_a.ctl_valid), 32'd0);
    cyc();
    bus_a.instr_valid = 1'b0;
    chk("a_add_ctl", 32'(get_a()), 32'(mk(OP_NONE, R_NONE, R_NONE, 5'd2, 4'h2, F_ALU)));

    // reset in the middle of a stall, with start asserted
    bus_a.instr_valid = 1'b1; bus_a.instr = 9'h11C;
    cyc();
    bus_a.instr_valid = 1'b0;
    chk("a_store_stall", 32'(bus_a.instr_ready), 32'd0);
    rst_a = 1'b1; bus_a.start = 1'b1;
    cyc();
    chk("a_mrst_ready",  32'(bus_a.instr_ready), 32'd0);
    chk("a_mrst_halted", 32'(bus_a.halted), 32'd0);
    chk("a_mrst_ctl",    32'(get_a()), 32'(DEF));
    chk("a_mrst_count",  32'(bus_a.instr_count), 32'd0);
    rst_a = 1'b0; bus_a.start = 1'b0;
    cyc();
    chk("a_mrst_idle", 32'(bus_a.instr_ready), 32'd0);

    // ---------------- dut_a random traffic vs model ----------------
    m_run = 1'b0; m_halt = 1'b0; m_wait = 0; m_cnt = 0;
    exp_ctl = DEF; pend = 1'b0; valid = 1'b0; w = '0;
    for (int k = 0; k < 3000; k++) begin
      chk("r_ready",  32'(bus_a.instr_ready), 32'(m_run && m_wait == 0));
      chk("r_halted", 32'(bus_a.halted), 32'(m_halt));
      chk("r_count",  32'(bus_a.instr_count), 32'(m_cnt));
      chk("r_ctl",    32'(get_a()), 32'(exp_ctl));
      if (!pend) begin
        valid = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 7) == 0) w = {4'b1000, 5'($urandom_range(0, 31))};
        else                           w = 9'($urandom_range(0, 511));
      end
      start = ($urandom_range(0, 4) == 0);
      bus_a.instr_valid = valid; bus_a.instr = w; bus_a.start = start;
      acc  = m_run && m_wait == 0 && valid;
      pend = valid && !acc;
      if (acc) begin
        c = model_decode(w, 1'b0);
        exp_ctl = c;
        if (m_cnt < 15) m_cnt++;
        if (c.done || c.illegal) begin
          m_run = 1'b0; m_halt = 1'b1;
        end else if (c.load_en || c.stor_en) begin
          m_wait = LAT_A - 1;
        end
      end else begin
        exp_ctl = DEF;
        if (m_wait > 0) m_wait--;
        else if (!m_run && start) begin m_run = 1'b1; m_halt = 1'b0; end
      end
      cyc();
    end
    bus_a.instr_valid = 1'b0; bus_a.start = 1'b0;

    // ---------------- dut_b table-driven decode ----------------
    rst_b = 1'b1; bus_b.start = 1'b1;
    cyc();
    rst_b = 1'b0; bus_b.start = 1'b0;
    chk("b_rst_over_start", 32'(bus_b.instr_ready), 32'd0);
    bus_b.start = 1'b1;
    cyc();
    bus_b.start = 1'b0;
    chk("b_start_ready", 32'(bus_b.instr_ready), 32'd1);
    b_cnt = 0;
    foreach (tbl[i]) begin
      n = 0;
      while (!bus_b.instr_ready && n < 10) begin
        bus_b.start = bus_b.halted;
        cyc();
        n++;
      end
      bus_b.start = 1'b0;
      chk("b_ready", 32'(bus_b.instr_ready), 32'd1);
      bus_b.instr_valid = 1'b1; bus_b.instr = tbl[i].instr;
      cyc();
      bus_b.instr_valid = 1'b0;
      b_cnt++;
      chk($sformatf("b_ctl_%h", tbl[i].instr), 32'(get_b()), 32'(tbl[i].exp));
      chk("b_halted", 32'(bus_b.halted), 32'(tbl[i].exp.done || tbl[i].exp.illegal));
      chk("b_count",  32'(bus_b.instr_count), 32'(b_cnt));
      cyc();
      chk("b_pulse", 32'(bus_b.ctl_valid), 32'd0);
    end

    // done halts; held instructions are not consumed until start
    n = 0;
    while (!bus_b.instr_ready && n < 10) begin
      bus_b.start = bus_b.halted;
      cyc();
      n++;
    end
    bus_b.start = 1'b0;
    bus_b.instr_valid = 1'b1; bus_b.instr = 9'h1FF;
    cyc();
    b_cnt++;
    chk("b_done",       32'(bus_b.done), 32'd1);
    chk("b_done_halt",  32'(bus_b.halted), 32'd1);
    chk("b_done_ready", 32'(bus_b.instr_ready), 32'd0);
    bus_b.instr = 9'h0A3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("b_halt_nodec", 32'(bus_b.ctl_valid), 32'd0);
    end
    chk("b_halt_count", 32'(bus_b.instr_count), 32'(b_cnt));
    bus_b.start = 1'b1;
    cyc();
    bus_b.start = 1'b0;
    chk("b_restart_ready",  32'(bus_b.instr_ready), 32'd1);
    chk("b_restart_halted", 32'(bus_b.halted), 32'd0);
    cyc();
    bus_b.instr_valid = 1'b0;
    chk("b_restart_ctl", 32'(get_b()), 32'(mk(OP_MOV, 5'd3, 5'd10, M_NONE, 4'h3, F_NO)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
